fb_swap_controller: RTL



---
 rtl/fb_pkg.sv | 35 +++
 rtl/fb_scan_counter.sv | 46 ++++
 rtl/fb_swap_controller.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared geometry, state encoding and pixel addressing for the frame buffer
//
// Purpose: constants and helpers shared by fb_swap_controller and fb_scan_counter.
// Ports:   none (package).
package fb_pkg;

    localparam int H_RES        = 640;
    localparam int V_RES        = 480;
    localparam int COLOR_W      = 3;
    localparam int ADDR_W       = 19;
    localparam int FRAME_PIXELS = H_RES * V_RES;

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } fb_state_e;

    // Linear pixel address y*h_res + x. The 640-wide raster uses the
    // 512+128 shift-add form; other widths fall back to a constant multiply.
    function automatic logic [ADDR_W-1:0] xy_to_addr(
        input logic [9:0] x,
        input logic [8:0] y,
        input int         h_res
    );
        logic [ADDR_W-1:0] ye;
        logic [ADDR_W-1:0] xe;
        ye = {{(ADDR_W-9){1'b0}}, y};
        xe = {{(ADDR_W-10){1'b0}}, x};
        if (h_res == 640) begin
            return (ye << 9) + (ye << 7) + xe;
        end
        return (ye * ADDR_W'(h_res)) + xe;
    endfunction

endpackage

// File: rtl/fb_scan_counter.sv
// rtl/fb_scan_counter.sv - scan-out read address counter with hold, wrap and last-pixel flag
//
// Purpose: steps the front-bank read address once per issued read.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   hold_i    : DVI FIFO full; no read issues and the address holds
//   addr_o    : current read address
//   issue_o   : a read issues this cycle
//   last_o    : the read issuing this cycle is the final pixel of the frame
module fb_scan_counter #(
    parameter int ADDR_W    = fb_pkg::ADDR_W,
    parameter int FRAME_LEN = fb_pkg::FRAME_PIXELS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              issue_o,
    output logic              last_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    assign issue_o = ~hold_i;
    assign last_o  = issue_o & (addr_q == LAST_ADDR);
    assign addr_o  = addr_q;

    always_comb begin
        addr_d = addr_q;
        if (issue_o) begin
            addr_d = last_o ? '0 : addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/fb_swap_controller.sv
// rtl/fb_swap_controller.sv - double-buffered frame memory sequencer (write, scan-out, swap, clear)
//
// Purpose: routes rasterizer pixels to the back bank, streams the front bank
// to the DVI FIFO, swaps banks at a frame boundary on request and clears the
// new back bank before rasterizing resumes.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   rast_pixel_rdy/x/y/color, ack     : rasterizer pixel write handshake
//   rast_done, next_frame_switch      : swap request (both high)
//   swap_pending                      : swap requested, not yet taken
//   mem_we/wr_bank/wr_addr/wdata      : combinational write port to back bank
//   mem_rd_bank/rd_addr, mem_rdata    : read port, data one cycle after address
//   dvi_fifo_full, write_enable, color: scan-out push into the DVI FIFO
module fb_swap_controller #(
    parameter int H_RES         = fb_pkg::H_RES,
    parameter int V_RES         = fb_pkg::V_RES,
    parameter int COLOR_W       = fb_pkg::COLOR_W,
    parameter int ADDR_W        = fb_pkg::ADDR_W,
    parameter int CLEAR_ON_SWAP = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rast_pixel_rdy,
    input  logic [9:0]         rast_x,
    input  logic [8:0]         rast_y,
    input  logic [COLOR_W-1:0] rast_color,
    output logic               rast_pixel_ack,
    input  logic               rast_done,
    input  logic               next_frame_switch,
    output logic               swap_pending,
    output logic               mem_we,
    output logic               mem_wr_bank,
    output logic [ADDR_W-1:0]  mem_wr_addr,
    output logic [COLOR_W-1:0] mem_wdata,
    output logic               mem_rd_bank,
    output logic [ADDR_W-1:0]  mem_rd_addr,
    input  logic [COLOR_W-1:0] mem_rdata,
    input  logic               dvi_fifo_full,
    output logic               dvi_fifo_write_enable,
    output logic [COLOR_W-1:0] dvi_color_out
);

    import fb_pkg::*;

    localparam int                FRAME_LEN = H_RES * V_RES;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

    fb_state_e         state_q, state_d;
    logic              front_sel_q, front_sel_d;
    logic              swap_pending_q, swap_pending_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              rd_issue_q;

    logic              rd_issue;
    logic              rd_last;
    logic              swap_req;
    logic              swap_take;
    logic              clr_last;
    logic              pix_in_range;
    logic [ADDR_W-1:0] pix_addr;

    fb_scan_counter #(
        .ADDR_W    (ADDR_W),
        .FRAME_LEN (FRAME_LEN)
    ) u_scan (
        .clk     (clk),
        .rst     (rst),
        .hold_i  (dvi_fifo_full),
        .addr_o  (mem_rd_addr),
        .issue_o (rd_issue),
        .last_o  (rd_last)
    );

    assign swap_req = rast_done & next_frame_switch;
    // The live request is OR-ed in so a request landing on the final read still swaps.
    assign swap_take = (state_q == RUN) & rd_last & (swap_pending_q | swap_req);
    assign clr_last  = (clr_addr_q == LAST_ADDR);

    assign pix_in_range = ({22'd0, rast_x} < 32'(H_RES)) && ({23'd0, rast_y} < 32'(V_RES));
    assign pix_addr     = ADDR_W'(xy_to_addr(rast_x, rast_y, H_RES));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            front_sel_q    <= 1'b0;
            swap_pending_q <= 1'b0;
            clr_addr_q     <= '0;
            rd_issue_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            front_sel_q    <= front_sel_d;
            swap_pending_q <= swap_pending_d;
            clr_addr_q     <= clr_addr_d;
            rd_issue_q     <= rd_issue;
        end
    end

    // Next-state logic; requests arriving during CLEAR stay latched until a RUN frame end.
    always_comb begin
        state_d        = state_q;
        front_sel_d    = front_sel_q;
        swap_pending_d = swap_pending_q | swap_req;
        clr_addr_d     = clr_addr_q;
        unique case (state_q)
            RUN: begin
                if (swap_take) begin
                    front_sel_d    = ~front_sel_q;
                    swap_pending_d = 1'b0;
                    clr_addr_d     = '0;
                    if (CLEAR_ON_SWAP != 0) begin
                        state_d = CLEAR;
                    end
                end
            end
            CLEAR: begin
                if (clr_last) begin
                    clr_addr_d = '0;
                    state_d    = RUN;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Output logic; write-port fields are zeroed when no write is strobed.
    always_comb begin
        rast_pixel_ack = 1'b0;
        mem_we         = 1'b0;
        mem_wr_bank    = 1'b0;
        mem_wr_addr    = '0;
        mem_wdata      = '0;
        if (!rst) begin
            unique case (state_q)
                RUN: begin
                    rast_pixel_ack = rast_pixel_rdy & ~swap_pending_q;
                    if (rast_pixel_ack && pix_in_range) begin
                        mem_we      = 1'b1;
                        mem_wr_bank = ~front_sel_q;
                        mem_wr_addr = pix_addr;
                        mem_wdata   = rast_color;
                    end
                end
                CLEAR: begin
                    mem_we      = 1'b1;
                    mem_wr_bank = ~front_sel_q;
                    mem_wr_addr = clr_addr_q;
                end
                default: ;
            endcase
        end
    end

    assign swap_pending          = swap_pending_q;
    assign mem_rd_bank           = front_sel_q;
    assign dvi_fifo_write_enable = rd_issue_q;
    assign dvi_color_out         = rd_issue_q ? mem_rdata : '0;

endmodule
